capture_buf_ctrl: RTL and testbench
===================================

CAPTURE_BUF_CTRL -- requirements
Module: capture_buf_ctrl

Interface
REQ-001 Parameter DW, default 1260: capture sample width in bits.
REQ-002 Parameter AW, default 9: buffer address width, giving 512 entries.
REQ-003 Parameter HW, default 32: host read word width.
REQ-004 Port clk, input, 1: single clock; all logic rises on clk.
REQ-005 Port rst, input, 1: reset, synchronous, active-high.
REQ-006 Ports arm and abort, input, 1 each: start a capture; force IDLE.
REQ-007 Ports cap_valid, input, 1, and cap_data, input, DW: sample strobe and sample.
REQ-008 Port trigger, input, 1: trigger qualifier, sampled only with cap_valid.
REQ-009 Port post_len, input, AW: samples stored after the trigger sample.
REQ-010 Port rd_req, input, 1, with rd_sample, input, AW, and rd_word, input, 6: host read request; sample index is relative to the oldest sample.
REQ-011 Ports rd_ack, output, 1; rd_err, output, 1; rd_data, output, HW: read response.
REQ-012 Ports state, output, 2; fill, output, AW+1; trig_idx, output, AW: status.
REQ-013 Ports mem_en, output, 1; mem_we, output, 1; mem_addr, output, AW; mem_din, output, DW; mem_dout, input, DW: drive the 512x1260 single-port buffer, which has 1-cycle read latency.

Function
REQ-014 States SHALL be IDLE=0, ARMED=1, POST=2, DONE=3, driven on state.
REQ-015 An arm in IDLE or DONE SHALL clear wr_ptr and fill and enter ARMED; arm in ARMED or POST SHALL be ignored.
REQ-016 In ARMED or POST, each cap_valid SHALL write cap_data at wr_ptr in the same cycle with mem_en=mem_we=1.
- wr_ptr increments and wraps 511->0.
- fill saturates at 512.
REQ-017 cap_valid&trigger in ARMED SHALL store that sample, latch trig_ptr=wr_ptr, load post_cnt=post_len, and enter POST; if post_len=0, enter DONE instead.
REQ-018 In POST, each stored sample SHALL decrement post_cnt; the write that takes it to 0 SHALL move to DONE on the next edge.
REQ-019 On entry to DONE, start_ptr SHALL equal wr_ptr if fill=512, else 0, and trig_idx SHALL equal (trig_ptr-start_ptr) mod 512.
REQ-020 abort SHALL enter IDLE from any state and beats arm in the same cycle; arm beats trigger in the same cycle.
REQ-021 rd_req in IDLE or DONE while no read is pending SHALL drive mem_en=1, mem_we=0, and mem_addr=(start_ptr+rd_sample) mod 512 in that cycle.
REQ-022 rd_ack SHALL pulse for one cycle exactly 2 cycles after the accepted rd_req, with rd_data=mem_dout[rd_word*HW +: HW]; bits beyond DW-1 read 0, and rd_word>39 returns 0 with rd_err=1.
REQ-023 rd_req while a read is pending SHALL be dropped, with no ack.
REQ-024 rd_req in ARMED or POST SHALL yield rd_ack with rd_err=1 and rd_data=0 after 2 cycles, with no memory access.
REQ-025 rd_sample>=fill SHALL yield rd_err=1; the memory data is still returned.
REQ-026 mem_en SHALL be 0 in cycles with no write and no accepted read; mem_din SHALL equal cap_data.

Reset
REQ-027 rst SHALL force state=IDLE and zero all of the following:
- wr_ptr, start_ptr, trig_ptr, trig_idx, post_cnt, fill
- rd_ack, rd_err, rd_data
- mem_en, mem_we
- read pipeline
REQ-028 rst mid-capture or mid-read SHALL discard the pending read without an ack; buffer contents are not cleared.

Configuration
REQ-029 With CAPTURE_BUF_DEDUP_EN defined, a cap_valid sample equal to the last stored sample SHALL not be stored, unless it carries trigger or is the first sample after arm; an identical sample in POST SHALL not decrement post_cnt.
REQ-030 Without CAPTURE_BUF_DEDUP_EN, every cap_valid sample SHALL be stored and no last-sample register SHALL exist.

Verification
REQ-031 Arm; 10 samples of value k=0..9; trigger on k=4 with post_len=5 -> DONE after the 10th write, fill=10, trig_idx=4; reading sample 4 word 0 returns 4 at rd_ack 2 cycles later.
REQ-032 Arm; 700 samples of value k; trigger on k=650 with post_len=49 -> fill=512, start_ptr=188, sample 0 reads 188, trig_idx=462.
REQ-033 post_len=0 with trigger on the first sample -> DONE the next cycle, fill=1, trig_idx=0.
REQ-034 arm+trigger+cap_valid in the same cycle from IDLE -> ARMED, one sample written, no trigger; abort+arm in the same cycle -> IDLE.
REQ-035 rd_req in POST -> rd_err=1 with rd_data=0; back-to-back rd_req in DONE -> only the first acked; rd_word=39 -> upper 20 bits 0.
REQ-036 With CAPTURE_BUF_DEDUP_EN: samples 5,5,5,6 after arm -> fill=2; rst during POST -> state=IDLE and no rd_ack.

Source files
------------

// File: rtl/capture_buf_ctrl_if.sv
// Host, capture and buffer-memory signal bundle for capture_buf_ctrl.
// The slave side is the controller; the master side is the system around it.
interface capture_buf_ctrl_if #(
   parameter int DW = 1260,
   parameter int AW = 9,
   parameter int HW = 32
);
   logic          arm;
   logic          abort;
   logic          cap_valid;
   logic [DW-1:0] cap_data;
   logic          trigger;
   logic [AW-1:0] post_len;
   logic          rd_req;
   logic [AW-1:0] rd_sample;
   logic [5:0]    rd_word;
   logic          rd_ack;
   logic          rd_err;
   logic [HW-1:0] rd_data;
   logic [1:0]    state;
   logic [AW:0]   fill;
   logic [AW-1:0] trig_idx;
   logic          mem_en;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_din;
   logic [DW-1:0] mem_dout;

   modport master (
      output arm, abort, cap_valid, cap_data, trigger, post_len,
             rd_req, rd_sample, rd_word, mem_dout,
      input  rd_ack, rd_err, rd_data, state, fill, trig_idx,
             mem_en, mem_we, mem_addr, mem_din
   );

   modport slave (
      input  arm, abort, cap_valid, cap_data, trigger, post_len,
             rd_req, rd_sample, rd_word, mem_dout,
      output rd_ack, rd_err, rd_data, state, fill, trig_idx,
             mem_en, mem_we, mem_addr, mem_din
   );
endinterface

// File: rtl/capture_buf_ctrl.sv
// Trigger-based circular capture buffer controller with a 2-cycle host read path.
// Optional feature: define CAPTURE_BUF_DEDUP_EN to skip storing repeated samples.
module capture_buf_ctrl #(
   parameter int DW = 1260,
   parameter int AW = 9,
   parameter int HW = 32
) (
   input logic              clk,
   input logic              rst,
   capture_buf_ctrl_if.slave bus
);
   localparam int          DEPTH     = 1 << AW;
   localparam int          NWORDS    = (DW + HW - 1) / HW;
   localparam int          PADW      = 64 * HW;
   localparam logic [AW:0] FILL_FULL = (AW + 1)'(DEPTH);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ARMED = 2'd1,
      ST_POST  = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   state_t        state_q, state_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] start_ptr_q, start_ptr_d;
   logic [AW-1:0] trig_ptr_q, trig_ptr_d;
   logic [AW-1:0] trig_idx_q, trig_idx_d;
   logic [AW-1:0] post_cnt_q, post_cnt_d;
   logic [AW:0]   fill_q, fill_d;
   logic          wr_s, arm_acc_s, dup_s, idle_like_s;
   logic [AW-1:0] wr_addr_s;
   logic          rd_acc_s, rd_mem_s, word_ok_s;
   logic          p1_q, p1_mem_q, p1_err_q;
   logic [5:0]    p1_word_q;
   logic          rd_ack_q, rd_err_q;
   logic [HW-1:0] rd_data_q;
   logic [PADW-1:0] pad_s;

   assign idle_like_s = (state_q == ST_IDLE) || (state_q == ST_DONE);

`ifdef CAPTURE_BUF_DEDUP_EN
   logic [DW-1:0] last_q;
   logic          first_q;

   // Last stored sample, and whether nothing has been stored since arm
   always_ff @(posedge clk) begin
      if (rst) begin
         last_q  <= '0;
         first_q <= 1'b0;
      end else begin
         if (wr_s) begin
            last_q  <= bus.cap_data;
            first_q <= 1'b0;
         end else if (arm_acc_s) begin
            last_q  <= last_q;
            first_q <= 1'b1;
         end else begin
            last_q  <= last_q;
            first_q <= first_q;
         end
      end
   end

   assign dup_s = (bus.cap_data == last_q) && !bus.trigger && !first_q;
`else
   assign dup_s = 1'b0;
`endif

   // Capture state register and pointers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         wr_ptr_q    <= '0;
         start_ptr_q <= '0;
         trig_ptr_q  <= '0;
         trig_idx_q  <= '0;
         post_cnt_q  <= '0;
         fill_q      <= '0;
      end else begin
         state_q     <= state_d;
         wr_ptr_q    <= wr_ptr_d;
         start_ptr_q <= start_ptr_d;
         trig_ptr_q  <= trig_ptr_d;
         trig_idx_q  <= trig_idx_d;
         post_cnt_q  <= post_cnt_d;
         fill_q      <= fill_d;
      end
   end

   // Next-state: abort beats arm, an accepted arm beats trigger
   always_comb begin
      state_d     = state_q;
      wr_ptr_d    = wr_ptr_q;
      start_ptr_d = start_ptr_q;
      trig_ptr_d  = trig_ptr_q;
      trig_idx_d  = trig_idx_q;
      post_cnt_d  = post_cnt_q;
      fill_d      = fill_q;
      wr_s        = 1'b0;
      wr_addr_s   = wr_ptr_q;
      arm_acc_s   = 1'b0;

      if (bus.abort) begin
         state_d = ST_IDLE;
      end else if (bus.arm && idle_like_s) begin
         // A sample arriving with the arm is stored as the first one
         arm_acc_s   = 1'b1;
         state_d     = ST_ARMED;
         start_ptr_d = '0;
         wr_addr_s   = '0;
         wr_s        = bus.cap_valid;
         wr_ptr_d    = bus.cap_valid ? AW'(1) : '0;
         fill_d      = bus.cap_valid ? (AW + 1)'(1) : '0;
      end else begin
         case (state_q)
            ST_ARMED, ST_POST: begin
               if (bus.cap_valid && !dup_s) begin
                  wr_s     = 1'b1;
                  wr_ptr_d = wr_ptr_q + AW'(1);
                  fill_d   = (fill_q == FILL_FULL) ? fill_q : fill_q + (AW + 1)'(1);
                  if (state_q == ST_POST) begin
                     post_cnt_d = post_cnt_q - AW'(1);
                     state_d    = (post_cnt_q == AW'(1)) ? ST_DONE : ST_POST;
                  end else if (bus.trigger) begin
                     trig_ptr_d = wr_ptr_q;
                     post_cnt_d = bus.post_len;
                     state_d    = (bus.post_len == '0) ? ST_DONE : ST_POST;
                  end else begin
                     state_d = ST_ARMED;
                  end
               end else begin
                  state_d = state_q;
               end
            end
            default: state_d = state_q;
         endcase
      end

      if ((state_d == ST_DONE) && (state_q != ST_DONE)) begin
         start_ptr_d = (fill_d == FILL_FULL) ? wr_ptr_d : '0;
         trig_idx_d  = trig_ptr_d - start_ptr_d;
      end else begin
         trig_idx_d = trig_idx_q;
      end
   end

   // Read acceptance; a capture write owns the single memory port
   always_comb begin
      rd_acc_s = bus.rd_req && !p1_q;
      rd_mem_s = rd_acc_s && idle_like_s && !wr_s;
   end

   assign bus.mem_en   = !rst && (wr_s || rd_mem_s);
   assign bus.mem_we   = !rst && wr_s;
   assign bus.mem_addr = wr_s ? wr_addr_s : start_ptr_q + bus.rd_sample;
   assign bus.mem_din  = bus.cap_data;

   // Read stage 1: request accepted, waiting for memory data
   always_ff @(posedge clk) begin
      if (rst) begin
         p1_q      <= 1'b0;
         p1_mem_q  <= 1'b0;
         p1_err_q  <= 1'b0;
         p1_word_q <= '0;
      end else begin
         p1_q      <= rd_acc_s;
         p1_mem_q  <= rd_mem_s;
         p1_err_q  <= !rd_mem_s || ({1'b0, bus.rd_sample} >= fill_q);
         p1_word_q <= bus.rd_word;
      end
   end

   assign pad_s     = {{(PADW - DW){1'b0}}, bus.mem_dout};
   assign word_ok_s = p1_mem_q && (p1_word_q < 6'(NWORDS));

   // Read stage 2: word select and response
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ack_q  <= 1'b0;
         rd_err_q  <= 1'b0;
         rd_data_q <= '0;
      end else begin
         rd_ack_q  <= p1_q;
         rd_err_q  <= p1_q && (p1_err_q || !word_ok_s);
         rd_data_q <= (p1_q && word_ok_s) ? pad_s[int'(p1_word_q) * HW +: HW] : '0;
      end
   end

   assign bus.rd_ack   = rd_ack_q;
   assign bus.rd_err   = rd_err_q;
   assign bus.rd_data  = rd_data_q;
   assign bus.state    = state_q;
   assign bus.fill     = fill_q;
   assign bus.trig_idx = trig_idx_q;
endmodule

// File: tb/tb_capture_buf_ctrl.sv
// Directed bench for capture_buf_ctrl with a behavioural 512-entry buffer memory.
// Build with CAPTURE_BUF_DEDUP_EN defined to exercise the dedup case.
module tb_capture_buf_ctrl;
   localparam int DW = 1260;
   localparam int AW = 9;
   localparam int HW = 32;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   vec_cnt = 0;
   int   err_cnt = 0;
   logic [DW-1:0] mem [512];
   logic [DW-1:0] ones;

   capture_buf_ctrl_if #(.DW(DW), .AW(AW), .HW(HW)) b ();

   capture_buf_ctrl #(.DW(DW), .AW(AW), .HW(HW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (b)
   );

   always #5 clk = ~clk;

   // Single-port buffer, 1-cycle read latency
   always @(posedge clk) begin
      if (b.mem_en) begin
         if (b.mem_we) mem[b.mem_addr] <= b.mem_din;
         else          b.mem_dout      <= mem[b.mem_addr];
      end
   end

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vec_cnt++;
      if (got !== exp) begin
         err_cnt++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic arm_it(input int plen);
      b.post_len = AW'(plen);
      b.arm = 1'b1;
      step();
      b.arm = 1'b0;
   endtask

   task automatic cap(input logic [DW-1:0] d, input logic trg);
      b.cap_valid = 1'b1;
      b.cap_data  = d;
      b.trigger   = trg;
      step();
      b.cap_valid = 1'b0;
      b.trigger   = 1'b0;
   endtask

   task automatic do_read(input string tag, input int smp, input int wrd, input logic exp_mem,
                          input int exp_addr, input logic [HW-1:0] exp_data, input logic exp_err);
      b.rd_req    = 1'b1;
      b.rd_sample = AW'(smp);
      b.rd_word   = 6'(wrd);
      #1;
      check_val({tag, "_en"}, 64'(b.mem_en), 64'(exp_mem));
      if (exp_mem) check_val({tag, "_addr"}, 64'(b.mem_addr), 64'(exp_addr));
      step();
      b.rd_req = 1'b0;
      check_val({tag, "_ack_early"}, 64'(b.rd_ack), 64'd0);
      step();
      check_val({tag, "_ack"}, 64'(b.rd_ack), 64'd1);
      check_val({tag, "_data"}, 64'(b.rd_data), 64'(exp_data));
      check_val({tag, "_err"}, 64'(b.rd_err), 64'(exp_err));
      step();
      check_val({tag, "_ack_late"}, 64'(b.rd_ack), 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      ones        = '1;
      b.arm       = 1'b0;
      b.abort     = 1'b0;
      b.cap_valid = 1'b0;
      b.cap_data  = '0;
      b.trigger   = 1'b0;
      b.post_len  = '0;
      b.rd_req    = 1'b0;
      b.rd_sample = '0;
      b.rd_word   = '0;
      b.mem_dout  = '0;
      rst         = 1'b1;
      step();
      step();
      rst = 1'b0;
      check_val("rst_state", 64'(b.state), 64'd0);
      check_val("rst_fill", 64'(b.fill), 64'd0);
      check_val("rst_trig_idx", 64'(b.trig_idx), 64'd0);
      check_val("rst_ack", 64'(b.rd_ack), 64'd0);
      check_val("rst_mem_en", 64'(b.mem_en), 64'd0);

      // 700 samples, trigger at 650, post 49: ring wraps
      arm_it(49);
      check_val("wrap_armed", 64'(b.state), 64'd1);
      for (int k = 0; k < 700; k++) cap(DW'(k), k == 650);
      check_val("wrap_state", 64'(b.state), 64'd3);
      check_val("wrap_fill", 64'(b.fill), 64'd512);
      check_val("wrap_trig_idx", 64'(b.trig_idx), 64'd462);
      do_read("wrap_s0", 0, 0, 1'b1, 188, 32'd188, 1'b0);
      do_read("wrap_s511", 511, 0, 1'b1, 187, 32'd699, 1'b0);

      // 10 samples, trigger at 4, post 5
      arm_it(5);
      b.cap_valid = 1'b1;
      b.cap_data  = '0;
      #1;
      check_val("wr_en", 64'(b.mem_en), 64'd1);
      check_val("wr_we", 64'(b.mem_we), 64'd1);
      check_val("wr_addr", 64'(b.mem_addr), 64'd0);
      for (int k = 0; k < 10; k++) begin
         cap(DW'(k), k == 4);
         if (k == 4) check_val("basic_post", 64'(b.state), 64'd2);
         if (k == 8) check_val("basic_still_post", 64'(b.state), 64'd2);
      end
      check_val("basic_done", 64'(b.state), 64'd3);
      check_val("basic_fill", 64'(b.fill), 64'd10);
      check_val("basic_trig_idx", 64'(b.trig_idx), 64'd4);
      check_val("idle_mem_en", 64'(b.mem_en), 64'd0);
      do_read("basic_s4", 4, 0, 1'b1, 4, 32'd4, 1'b0);
      do_read("basic_s9w1", 9, 1, 1'b1, 9, 32'd0, 1'b0);
      do_read("beyond_fill", 10, 0, 1'b1, 10, 32'd522, 1'b1);
      do_read("word40", 4, 40, 1'b1, 4, 32'd0, 1'b1);

      // post_len 0 with trigger on first sample
      arm_it(0);
      cap(DW'(7), 1'b1);
      check_val("p0_state", 64'(b.state), 64'd3);
      check_val("p0_fill", 64'(b.fill), 64'd1);
      check_val("p0_trig_idx", 64'(b.trig_idx), 64'd0);
      do_read("p0_s0", 0, 0, 1'b1, 0, 32'd7, 1'b0);

      // arm+trigger+cap_valid from DONE: stored, trigger ignored
      b.post_len  = '0;
      b.arm       = 1'b1;
      b.trigger   = 1'b1;
      b.cap_valid = 1'b1;
      b.cap_data  = DW'(33);
      #1;
      check_val("armcap_we", 64'(b.mem_we), 64'd1);
      check_val("armcap_addr", 64'(b.mem_addr), 64'd0);
      step();
      b.arm = 1'b0; b.trigger = 1'b0; b.cap_valid = 1'b0;
      check_val("armcap_state", 64'(b.state), 64'd1);
      check_val("armcap_fill", 64'(b.fill), 64'd1);
      b.abort = 1'b1; b.arm = 1'b1;
      step();
      check_val("abort_armed", 64'(b.state), 64'd0);
      step();
      b.abort = 1'b0; b.arm = 1'b0;
      check_val("abort_arm_idle", 64'(b.state), 64'd0);

      // read in POST, then word 39 and back-to-back reads in DONE
      arm_it(3);
      cap(DW'(1), 1'b0);
      cap(DW'(2), 1'b1);
      check_val("rp_post", 64'(b.state), 64'd2);
      do_read("post_rd", 0, 0, 1'b0, 0, 32'd0, 1'b1);
      cap(ones, 1'b0);
      cap(DW'(3), 1'b0);
      cap(DW'(4), 1'b0);
      check_val("rp_done", 64'(b.state), 64'd3);
      check_val("rp_fill", 64'(b.fill), 64'd5);
      check_val("rp_trig_idx", 64'(b.trig_idx), 64'd1);
      do_read("w39", 2, 39, 1'b1, 2, 32'h0000_0FFF, 1'b0);
      do_read("w38", 2, 38, 1'b1, 2, 32'hFFFF_FFFF, 1'b0);
      b.rd_req = 1'b1; b.rd_sample = '0; b.rd_word = '0;
      step();
      check_val("b2b_drop_en", 64'(b.mem_en), 64'd0);
      step();
      b.rd_req = 1'b0;
      check_val("b2b_ack1", 64'(b.rd_ack), 64'd1);
      check_val("b2b_data1", 64'(b.rd_data), 64'd1);
      step();
      check_val("b2b_no_ack2", 64'(b.rd_ack), 64'd0);
      step();
      check_val("b2b_no_ack3", 64'(b.rd_ack), 64'd0);

      // reset during POST with a read in flight
      arm_it(5);
      cap(DW'(9), 1'b1);
      check_val("rstp_post", 64'(b.state), 64'd2);
      b.rd_req = 1'b1;
      step();
      b.rd_req = 1'b0;
      rst = 1'b1;
      step();
      rst = 1'b0;
      check_val("rstp_state", 64'(b.state), 64'd0);
      check_val("rstp_fill", 64'(b.fill), 64'd0);
      check_val("rstp_ack", 64'(b.rd_ack), 64'd0);
      step();
      check_val("rstp_ack_late", 64'(b.rd_ack), 64'd0);

      // repeated samples 5,5,5,6
      arm_it(0);
      cap(DW'(5), 1'b0);
      cap(DW'(5), 1'b0);
      cap(DW'(5), 1'b0);
      cap(DW'(6), 1'b0);
`ifdef CAPTURE_BUF_DEDUP_EN
      check_val("dedup_fill", 64'(b.fill), 64'd2);
`else
      check_val("nodedup_fill", 64'(b.fill), 64'd4);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end
endmodule
